// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer for a single-issue fetch stage.
//
// Holds the fetch address and chooses the next one. A redirect is taken at once
// when the pc can advance. Otherwise its target waits in a pending register until
// the next update. A decoded halt stops fetching until reset.
//
// Parameters:
//   PC_INIT      - pc value loaded on reset
// Ports:
//   CLK          - clock, rising edge
//   nRST         - asynchronous active-low reset
//   ihit         - instruction memory returned the word for pc this cycle
//   stall        - hazard hold, blocks pc update
//   halt         - halt instruction decoded
//   redirect     - control-flow change valid this cycle
//   pc_sel[2:0]  - 0 jump (J-type), 1 jump register, 2 branch, 3 next instr
//   jr_addr      - register jump target
//   jump_imm     - J-type target field
//   imm16        - branch offset in words
//   branch_base  - npc of the redirecting instruction
//   pc           - current fetch address (registered)
//   npc          - pc + 4 (combinational, wraps)
//   imem_ren     - instruction fetch request
//   halted       - sequencer stopped
//   misalign     - sticky misaligned-target flag
//
// Build option: define PC_SEQ_ALIGN_CHECK_EN to trap misaligned targets by setting
// misalign and halting. Without it, target bits [1:0] are cleared.

module pc_sequencer #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic        stall,
    input  logic        halt,
    input  logic        redirect,
    input  logic [2:0]  pc_sel,
    input  logic [31:0] jr_addr,
    input  logic [25:0] jump_imm,
    input  logic [15:0] imm16,
    input  logic [31:0] branch_base,
    output logic [31:0] pc,
    output logic [31:0] npc,
    output logic        imem_ren,
    output logic        halted,
    output logic        misalign
);

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StPend,
        StHalted
    } state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] pend_q;
    logic        imem_ren_q;
    logic        halted_q;

    logic        active;
    logic        update;
    logic        valid_redirect;
    logic        bad_target;
    logic [31:0] imm_offset;
    logic [31:0] raw_target;
    logic [31:0] target;

    assign active         = (state_q == StFetch) || (state_q == StPend);
    assign update         = active && ihit && !stall;
    // Only selections 0..2 name a target; 3 and the unused codes are no-ops.
    assign valid_redirect = redirect && (pc_sel < 3'd3);
    assign imm_offset     = {{14{imm16[15]}}, imm16, 2'b00};
    assign npc            = pc_q + 32'd4;

    always_comb begin
        raw_target = '0;
        case (pc_sel)
            3'd0:    raw_target = {branch_base[31:28], jump_imm, 2'b00};
            3'd1:    raw_target = jr_addr;
            3'd2:    raw_target = branch_base + imm_offset;
            default: raw_target = '0;
        endcase
    end

`ifdef PC_SEQ_ALIGN_CHECK_EN
    logic misalign_q;

    assign target     = raw_target;
    assign bad_target = valid_redirect && (raw_target[1:0] != 2'b00);
    assign misalign   = misalign_q;
`else
    assign target     = raw_target & 32'hFFFF_FFFC;
    assign bad_target = 1'b0;
    assign misalign   = 1'b0;
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= StIdle;
            pc_q       <= PC_INIT;
            pend_q     <= '0;
            imem_ren_q <= 1'b0;
            halted_q   <= 1'b0;
`ifdef PC_SEQ_ALIGN_CHECK_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    state_q    <= StFetch;
                    imem_ren_q <= 1'b1;
                end
                StFetch, StPend: begin
                    // Halt wins over any same-cycle redirect or update.
                    if (halt) begin
                        state_q    <= StHalted;
                        imem_ren_q <= 1'b0;
                        halted_q   <= 1'b1;
                    end else if (bad_target) begin
                        state_q    <= StHalted;
                        imem_ren_q <= 1'b0;
                        halted_q   <= 1'b1;
`ifdef PC_SEQ_ALIGN_CHECK_EN
                        misalign_q <= 1'b1;
`endif
                    end else if (update) begin
                        if (valid_redirect) begin
                            pc_q <= target;
                        end else if (state_q == StPend) begin
                            pc_q <= pend_q;
                        end else begin
                            pc_q <= npc;
                        end
                        pend_q  <= '0;
                        state_q <= StFetch;
                    end else if (valid_redirect) begin
                        // Later redirects overwrite an older pending target.
                        pend_q  <= target;
                        state_q <= StPend;
                    end
                end
                StHalted: begin
                    state_q <= StHalted;
                end
                default: begin
                    state_q    <= StIdle;
                    imem_ren_q <= 1'b0;
                end
            endcase
        end
    end

    assign pc       = pc_q;
    assign imem_ren = imem_ren_q;
    assign halted   = halted_q;

endmodule
